// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and flit header layout for the router input port
//
// Purpose: flit type, direction and per-VC state enums plus header field
// offsets used by vc_input_unit and vc_fifo.
// Ports: none (package).
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package router_pkg;

    typedef enum logic [1:0] {
        BODY      = 2'b00,
        HEAD      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        N     = 3'd0,
        S     = 3'd1,
        W     = 3'd2,
        E     = 3'd3,
        EJECT = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        IDLE,
        ROUTING,
        WAIT_VA,
        ACTIVE
    } vc_state_e;

    // Header: destination router id in the top bits, flit type right below it.
    localparam int FLIT_W    = `FLIT_DATA_WIDTH;
    localparam int DEST_MSB  = FLIT_W - 1;
    localparam int TYPE_BITS = 2;

    function automatic logic is_head(input flit_type_e t);
        return (t == HEAD) || (t == HEAD_TAIL);
    endfunction

    function automatic logic is_tail(input flit_type_e t);
        return (t == TAIL) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - single virtual-channel circular flit buffer
//
// Purpose: DEPTH-entry circular buffer with simultaneous push/pop. A push
// while full is accepted only when a pop happens in the same cycle;
// otherwise it is dropped.
// Ports: clk, reset (async active-high), push/push_data (write), pop (read
// front), front (head-of-queue data), full, empty.
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] front,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign front   = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vc_input_unit.sv
// rtl/vc_input_unit.sv - mesh router input port with per-VC FIFOs, XY routing and VA/SA handshake
//
// Purpose: buffers incoming flits per VC, computes the XY output port for
// each packet, requests an output VC then the crossbar, and launches
// granted flits with their downstream VC while returning a credit.
// Ports: clk, reset (async active-high); in_flit/in_valid/in_vc (arrivals);
// credit_valid/credit_vc (upstream credit); va_req/va_port/va_grant/
// va_out_vc (VC allocation); sa_req/sa_grant/credit_ok (switch allocation);
// out_flit/out_valid/out_port/out_vc (departures).
// Optional: ROUTER_IP_OVERFLOW_CHECK_EN adds sticky ovf_err for writes to a
// full VC and multi-hot sa_grant.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module vc_input_unit
    import router_pkg::*;
#(
    parameter int NUM_PORTS      = 5,
    parameter int NUM_VC         = 4,
    parameter int VC_DEPTH       = 4,
    parameter int NUM_ROUTERS    = 16,
    parameter int ROUTER_PER_ROW = 4,
    parameter int ROUTER_ID      = 0,
    parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
    parameter int VC_BITS        = $clog2(NUM_VC)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [`FLIT_DATA_WIDTH-1:0]  in_flit,
    input  logic                         in_valid,
    input  logic [VC_BITS-1:0]           in_vc,
    output logic                         credit_valid,
    output logic [VC_BITS-1:0]           credit_vc,
    output logic [NUM_VC-1:0]            va_req,
    output logic [NUM_VC*NUM_PORTS-1:0]  va_port,
    input  logic [NUM_VC-1:0]            va_grant,
    input  logic [NUM_VC*VC_BITS-1:0]    va_out_vc,
    output logic [NUM_VC-1:0]            sa_req,
    input  logic [NUM_VC-1:0]            sa_grant,
    input  logic [NUM_VC-1:0]            credit_ok,
    output logic [`FLIT_DATA_WIDTH-1:0]  out_flit,
    output logic                         out_valid,
    output logic [NUM_PORTS-1:0]         out_port,
    output logic [VC_BITS-1:0]           out_vc
`ifdef ROUTER_IP_OVERFLOW_CHECK_EN
    ,
    output logic                         ovf_err
`endif
);

    localparam int TYPE_MSB = DEST_MSB - ROUTER_ID_BITS;
    localparam int OWN_ROW  = ROUTER_ID / ROUTER_PER_ROW;
    localparam int OWN_COL  = ROUTER_ID % ROUTER_PER_ROW;

    vc_state_e            state     [NUM_VC];
    vc_state_e            state_nxt [NUM_VC];
    logic [NUM_PORTS-1:0] route     [NUM_VC];
    logic [VC_BITS-1:0]   alloc_vc  [NUM_VC];
    logic [FLIT_W-1:0]    front     [NUM_VC];
    logic [NUM_VC-1:0]    push, pop, full, empty, head_at_front, tail_at_front;
    logic                 sel_valid;
    logic [VC_BITS-1:0]   sel_vc;

    // Dimension-ordered routing: resolve the column first, then the row.
    function automatic logic [NUM_PORTS-1:0] xy_route(input logic [ROUTER_ID_BITS-1:0] dest);
        int row;
        int col;
        row = int'(dest) / ROUTER_PER_ROW;
        col = int'(dest) % ROUTER_PER_ROW;
        xy_route = '0;
        if (col < OWN_COL)      xy_route[W]     = 1'b1;
        else if (col > OWN_COL) xy_route[E]     = 1'b1;
        else if (row < OWN_ROW) xy_route[N]     = 1'b1;
        else if (row > OWN_ROW) xy_route[S]     = 1'b1;
        else                    xy_route[EJECT] = 1'b1;
    endfunction

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign push[v] = in_valid && (in_vc == VC_BITS'(v));

        vc_fifo #(
            .DEPTH (VC_DEPTH),
            .WIDTH (FLIT_W)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[v]),
            .push_data (in_flit),
            .pop       (pop[v]),
            .front     (front[v]),
            .full      (full[v]),
            .empty     (empty[v])
        );

        assign head_at_front[v] = is_head(flit_type_e'(front[v][TYPE_MSB -: TYPE_BITS]));
        assign tail_at_front[v] = is_tail(flit_type_e'(front[v][TYPE_MSB -: TYPE_BITS]));
    end

    always_comb begin
        va_req  = '0;
        va_port = '0;
        sa_req  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (state[v] == WAIT_VA) begin
                va_req[v] = 1'b1;
                va_port[v*NUM_PORTS +: NUM_PORTS] = route[v];
            end
            if (state[v] == ACTIVE) sa_req[v] = !empty[v] && credit_ok[v];
        end
    end

    // Only grants that meet a live request count; a multi-hot grant still
    // launches a single flit (lowest VC) since there is one output register.
    always_comb begin
        sel_valid = 1'b0;
        sel_vc    = '0;
        pop       = '0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (sa_grant[v] && sa_req[v]) begin
                sel_valid = 1'b1;
                sel_vc    = VC_BITS'(v);
            end
        end
        pop[sel_vc] = sel_valid;
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            state_nxt[v] = state[v];
            case (state[v])
                // A body flit at the front of an idle VC is a protocol error; it stays parked.
                IDLE:    if (!empty[v] && head_at_front[v]) state_nxt[v] = ROUTING;
                ROUTING: state_nxt[v] = WAIT_VA;
                WAIT_VA: if (va_grant[v]) state_nxt[v] = ACTIVE;
                ACTIVE:  if (pop[v] && tail_at_front[v]) state_nxt[v] = IDLE;
                default: state_nxt[v] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state[v]    <= IDLE;
                route[v]    <= '0;
                alloc_vc[v] <= '0;
            end
            out_valid    <= 1'b0;
            credit_valid <= 1'b0;
            out_flit     <= '0;
            out_port     <= '0;
            out_vc       <= '0;
            credit_vc    <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                state[v] <= state_nxt[v];
                if (state[v] == ROUTING)
                    route[v] <= xy_route(front[v][DEST_MSB -: ROUTER_ID_BITS]);
                if (state[v] == WAIT_VA && va_grant[v])
                    alloc_vc[v] <= va_out_vc[v*VC_BITS +: VC_BITS];
            end
            out_valid    <= sel_valid;
            credit_valid <= sel_valid;
            if (sel_valid) begin
                out_flit  <= front[sel_vc];
                out_port  <= route[sel_vc];
                out_vc    <= alloc_vc[sel_vc];
                credit_vc <= sel_vc;
            end
        end
    end

`ifdef ROUTER_IP_OVERFLOW_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
        end else if ((in_valid && full[in_vc] && !pop[in_vc]) || ($countones(sa_grant) > 1)) begin
            ovf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_input_unit.sv
// tb/tb_vc_input_unit.sv - self-checking bench for vc_input_unit
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module tb_vc_input_unit;

    localparam int NV    = 4;
    localparam int NP    = 5;
    localparam int VB    = 2;
    localparam int FW    = `FLIT_DATA_WIDTH;
    localparam int RPR   = 4;
    localparam int OWN_R = 0;
    localparam int OWN_C = 0;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [FW-1:0]     in_flit = '0;
    logic              in_valid = 1'b0;
    logic [VB-1:0]     in_vc = '0;
    logic              credit_valid;
    logic [VB-1:0]     credit_vc;
    logic [NV-1:0]     va_req;
    logic [NV*NP-1:0]  va_port;
    logic [NV-1:0]     va_grant = '0;
    logic [NV*VB-1:0]  va_out_vc = '0;
    logic [NV-1:0]     sa_req;
    logic [NV-1:0]     sa_grant = '0;
    logic [NV-1:0]     credit_ok = '1;
    logic [FW-1:0]     out_flit;
    logic              out_valid;
    logic [NP-1:0]     out_port;
    logic [VB-1:0]     out_vc;
`ifdef ROUTER_IP_OVERFLOW_CHECK_EN
    logic              ovf_err;
`endif

    vc_input_unit dut (
        .clk          (clk),
        .reset        (reset),
        .in_flit      (in_flit),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .va_req       (va_req),
        .va_port      (va_port),
        .va_grant     (va_grant),
        .va_out_vc    (va_out_vc),
        .sa_req       (sa_req),
        .sa_grant     (sa_grant),
        .credit_ok    (credit_ok),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .out_port     (out_port),
        .out_vc       (out_vc)
`ifdef ROUTER_IP_OVERFLOW_CHECK_EN
        ,
        .ovf_err      (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] flit;
        logic [NP-1:0] port;
        logic [VB-1:0] ovc;
        logic [VB-1:0] src;
    } exp_t;

    exp_t          sb[$];
    logic [VB-1:0] va_tbl [NV] = '{2'd2, 2'd3, 2'd3, 2'd1};
    int            total = 0;
    int            passed = 0;
    int            rr_last = 0;

    function automatic logic [NP-1:0] model_port(input int dest);
        int r;
        int c;
        r = dest / RPR;
        c = dest % RPR;
        if (c < OWN_C) return 5'b00100;
        if (c > OWN_C) return 5'b01000;
        if (r < OWN_R) return 5'b00001;
        if (r > OWN_R) return 5'b00010;
        return 5'b10000;
    endfunction

    function automatic int find_src(input logic [VB-1:0] s);
        foreach (sb[i]) if (sb[i].src == s) return i;
        return -1;
    endfunction

    task automatic drive(input int vc, input int dest, input logic [1:0] ty, input int pay, input bit keep);
        logic [FW-1:0] f;
        f = {4'(dest), ty, 26'(pay)};
        in_valid = 1'b1;
        in_vc    = VB'(vc);
        in_flit  = f;
        if (keep) sb.push_back('{f, model_port(dest), va_tbl[vc], VB'(vc)});
    endtask

    // VA is granted to every VC each cycle; SA is round-robin over live requests.
    task automatic tick();
        #1;
        va_grant = '1;
        sa_grant = '0;
        for (int k = 1; k <= NV; k++) begin
            int i;
            i = (rr_last + k) % NV;
            if (sa_grant == '0 && sa_req[i]) begin
                sa_grant[i] = 1'b1;
                rr_last = i;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        va_grant = '0;
        sa_grant = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, credit_valid, va_req, sa_req} !== '0)
            $display("FAIL reset_ctrl: got %b, required 0", {out_valid, credit_valid, va_req, sa_req});
        else passed++;
        total++;
        if ({out_flit, out_port, out_vc, credit_vc} !== '0)
            $display("FAIL reset_data: got flit=%h port=%b vc=%0d cvc=%0d, required 0", out_flit, out_port, out_vc, credit_vc);
        else passed++;
        total++;
        if (va_port !== '0) $display("FAIL reset_va_port: got %b, required 0", va_port);
        else passed++;
`ifdef ROUTER_IP_OVERFLOW_CHECK_EN
        total++;
        if (ovf_err !== 1'b0) $display("FAIL reset_ovf: got %b, required 0", ovf_err);
        else passed++;
`endif
        reset = 1'b0;
    endtask

    task automatic test_single_latency();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) drive(2, 5, 2'b11, 'h111, 1);
            tick();
            total++;
            if (out_valid !== (c == 4)) $display("FAIL latency_c%0d: out_valid=%b, required %b", c, out_valid, (c == 4));
            else passed++;
            if (c == 2) begin
                total++;
                if (va_req !== 4'b0100 || va_port[2*NP +: NP] !== 5'b01000)
                    $display("FAIL single_va: va_req=%b port=%b, required 0100 01000", va_req, va_port[2*NP +: NP]);
                else passed++;
            end
            if (out_valid) begin
                int k = find_src(credit_vc);
                total++;
                if (k < 0) $display("FAIL single_unexpected: flit=%h cvc=%0d, required none", out_flit, credit_vc);
                else if (out_flit !== sb[k].flit || out_port !== sb[k].port || out_vc !== sb[k].ovc || credit_valid !== 1'b1)
                    $display("FAIL single_flit: got %h/%b/%0d cv=%b, required %h/%b/%0d", out_flit, out_port, out_vc, credit_valid, sb[k].flit, sb[k].port, sb[k].ovc);
                else passed++;
                if (k >= 0) sb.delete(k);
            end
        end
        total++;
        if (sb.size() != 0) $display("FAIL single_missing: %0d pending, required 0", sb.size());
        else passed++;
    endtask

    task automatic test_packet_burst();
        int n = 0;
        int first = -1;
        int last = -1;
        for (int c = 0; c < 12; c++) begin
            if (c == 0) drive(1, 3, 2'b01, 'h201, 1);
            if (c == 1) drive(1, 3, 2'b00, 'h202, 1);
            if (c == 2) drive(1, 3, 2'b10, 'h203, 1);
            tick();
            if (out_valid) begin
                int k = find_src(credit_vc);
                n++;
                if (first < 0) first = c;
                last = c;
                total++;
                if (k < 0) $display("FAIL burst_unexpected: flit=%h cvc=%0d, required none", out_flit, credit_vc);
                else if (out_flit !== sb[k].flit || out_port !== sb[k].port || out_vc !== sb[k].ovc || credit_valid !== 1'b1)
                    $display("FAIL burst_flit: got %h/%b/%0d cv=%b, required %h/%b/%0d", out_flit, out_port, out_vc, credit_valid, sb[k].flit, sb[k].port, sb[k].ovc);
                else passed++;
                if (k >= 0) sb.delete(k);
            end
        end
        total++;
        if (n != 3 || last - first != 2) $display("FAIL burst_consecutive: count=%0d span=%0d, required 3 and 2", n, last - first);
        else passed++;
        total++;
        if (sa_req !== '0 || va_req !== '0 || sb.size() != 0)
            $display("FAIL burst_idle: sa_req=%b va_req=%b pending=%0d, required 0", sa_req, va_req, sb.size());
        else passed++;
    endtask

    task automatic test_credit_stall();
        int n = 0;
        credit_ok = 4'b1110;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) drive(0, 4, (c == 0) ? 2'b01 : ((c == 3) ? 2'b10 : 2'b00), 'h300 + c, 1);
            if (c == 4) drive(0, 4, 2'b11, 'hBAD, 0);
            tick();
            if (out_valid || credit_valid) n++;
        end
        total++;
        if (n != 0 || sa_req[0] !== 1'b0) $display("FAIL stall_hold: outputs=%0d sa_req0=%b, required 0 0", n, sa_req[0]);
        else passed++;
`ifdef ROUTER_IP_OVERFLOW_CHECK_EN
        total++;
        if (ovf_err !== 1'b1) $display("FAIL stall_ovf: got %b, required 1", ovf_err);
        else passed++;
`endif
        credit_ok = '1;
        for (int ph = 0; ph < 2; ph++) begin
            n = 0;
            for (int c = 0; c < 12; c++) begin
                if (ph == 1 && c < 4) drive(0, 4, (c == 0) ? 2'b01 : ((c == 3) ? 2'b10 : 2'b00), 'h400 + c, 1);
                tick();
                if (out_valid) begin
                    int k = find_src(credit_vc);
                    n++;
                    total++;
                    if (k < 0) $display("FAIL stall_unexpected: flit=%h cvc=%0d, required none", out_flit, credit_vc);
                    else if (out_flit !== sb[k].flit || out_port !== sb[k].port || out_vc !== sb[k].ovc || credit_valid !== 1'b1)
                        $display("FAIL stall_flit: got %h/%b/%0d cv=%b, required %h/%b/%0d", out_flit, out_port, out_vc, credit_valid, sb[k].flit, sb[k].port, sb[k].ovc);
                    else passed++;
                    if (k >= 0) sb.delete(k);
                end
            end
            total++;
            if (n != 4) $display("FAIL stall_drain_ph%0d: count=%0d, required 4", ph, n);
            else passed++;
        end
        total++;
        if (sb.size() != 0) $display("FAIL stall_missing: %0d pending, required 0", sb.size());
        else passed++;
    endtask

    task automatic test_interleave();
        int n = 0;
        int sw = 0;
        int prev = -1;
        for (int c = 0; c < 16; c++) begin
            if (c < 6) drive((c % 2 == 0) ? 0 : 3, (c % 2 == 0) ? 1 : 8,
                             (c < 2) ? 2'b01 : ((c < 4) ? 2'b00 : 2'b10), 'h500 + c, 1);
            tick();
            if (out_valid) begin
                int k = find_src(credit_vc);
                n++;
                if (prev >= 0 && prev != int'(credit_vc)) sw++;
                prev = int'(credit_vc);
                total++;
                if (k < 0) $display("FAIL inter_unexpected: flit=%h cvc=%0d, required none", out_flit, credit_vc);
                else if (out_flit !== sb[k].flit || out_port !== sb[k].port || out_vc !== sb[k].ovc || credit_valid !== 1'b1)
                    $display("FAIL inter_flit: got %h/%b/%0d cv=%b, required %h/%b/%0d", out_flit, out_port, out_vc, credit_valid, sb[k].flit, sb[k].port, sb[k].ovc);
                else passed++;
                if (k >= 0) sb.delete(k);
            end
        end
        total++;
        if (n != 6 || sw != 5 || sb.size() != 0)
            $display("FAIL inter_alternate: count=%0d switches=%0d pending=%0d, required 6 5 0", n, sw, sb.size());
        else passed++;
    endtask

    task automatic test_eject_reset();
        bit got = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 0) drive(2, 0, 2'b11, 'h600, 1);
            tick();
            if (out_valid) begin
                int k = find_src(credit_vc);
                total++;
                if (k < 0) $display("FAIL eject_unexpected: flit=%h cvc=%0d, required none", out_flit, credit_vc);
                else if (out_flit !== sb[k].flit || out_port !== 5'b10000 || out_vc !== sb[k].ovc)
                    $display("FAIL eject_flit: got %h/%b/%0d, required %h/10000/%0d", out_flit, out_port, out_vc, sb[k].flit, sb[k].ovc);
                else passed++;
                if (k >= 0) sb.delete(k);
            end
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 0) drive(1, 0, 2'b01, 'h610, 1);
            if (c == 1 || c == 2) drive(1, 0, 2'b00, 'h610 + c, 1);
            tick();
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        total++;
        if (!got) $display("FAIL reset_wait: no flit within 10 cycles, required one");
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if ({out_valid, credit_valid, va_req, sa_req} !== '0 || {out_flit, out_port, out_vc, credit_vc} !== '0)
            $display("FAIL reset_async: ctrl=%b flit=%h port=%b, required all 0", {out_valid, credit_valid, va_req, sa_req}, out_flit, out_port);
        else passed++;
        #1;
        reset = 1'b0;
        sb.delete();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) drive(1, 5, 2'b11, 'h699, 1);
            tick();
            total++;
            if (out_valid !== (c == 4)) $display("FAIL post_reset_c%0d: out_valid=%b, required %b", c, out_valid, (c == 4));
            else passed++;
            if (out_valid) begin
                int k = find_src(credit_vc);
                total++;
                if (k < 0) $display("FAIL post_reset_unexpected: flit=%h cvc=%0d, required none", out_flit, credit_vc);
                else if (out_flit !== sb[k].flit || out_port !== sb[k].port || out_vc !== sb[k].ovc)
                    $display("FAIL post_reset_flit: got %h/%b/%0d, required %h/%b/%0d", out_flit, out_port, out_vc, sb[k].flit, sb[k].port, sb[k].ovc);
                else passed++;
                if (k >= 0) sb.delete(k);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        va_out_vc = {va_tbl[3], va_tbl[2], va_tbl[1], va_tbl[0]};
        test_reset();
        test_single_latency();
        test_packet_burst();
        test_credit_stall();
        test_interleave();
        test_eject_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
